// File: rtl/pico_fifo_pkg.sv
// Shared definitions for the parametrised PicoBlaze FIFO: read-mode
// encoding, default almost-full/almost-empty settings and the helper
// that sizes the occupancy counter.
package pico_fifo_pkg;

  // Read-port behaviour of the FIFO.
  typedef enum logic {
    FIFO_STD  = 1'b0,  // registered read, data one cycle after rd_en
    FIFO_FWFT = 1'b1   // head entry always presented on dout
  } fifo_mode_e;

  // almost_empty default: asserted at or below this many entries.
  localparam int AE_THRESH_DEF = 2;
  // almost_full default: asserted this many entries below full.
  localparam int AF_MARGIN_DEF = 2;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pico_fifo_ram.sv
// Simple dual-port storage for the FIFO: one synchronous write port and
// one synchronous read port. The array itself is not reset; only the read
// data register is, so the FIFO output is clean coming out of reset.
module pico_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at wr_addr.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: capture mem[rd_addr]; holds its value when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pico_fifo_param.sv
// Parametrised single-channel FIFO between a producer and a consumer
// PicoBlaze. Provides standard or first-word-fall-through reads, an
// occupancy count, programmable almost flags, synchronous flush and
// sticky overflow/underflow indications.
//
// Handshake: a write happens on a rising edge when wr_en is high and the
// FIFO is not full (full acts as the inverse of ready); a read happens
// when rd_en is high and the FIFO is not empty. flush overrides both.
// Requests made against full/empty are dropped and flagged as
// overflow/underflow; they never stall or alter the contents.
module pico_fifo_param
  import pico_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - AF_MARGIN_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [clog2_cnt(DEPTH)-1:0]   count,
  input  logic                          flush,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         CW      = clog2_cnt(DEPTH);
  localparam fifo_mode_e MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]    count_q, count_nx;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, unf_q;
  logic             dv_q;
  logic             byp_sel_q;
  logic [WIDTH-1:0] byp_data_q;
  logic             wr_accept, rd_accept;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic [WIDTH-1:0] head;

  assign wr_accept = wr_en && !full_q  && !flush;
  assign rd_accept = rd_en && !empty_q && !flush;

  // Next pointers and occupancy; flush returns everything to the origin.
  always_comb begin
    wr_ptr_nx = wr_ptr_q;
    rd_ptr_nx = rd_ptr_q;
    count_nx  = count_q;
    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      if (wr_accept) wr_ptr_nx = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_nx = rd_ptr_q + AW'(1);
      if (wr_accept && !rd_accept)      count_nx = count_q + CW'(1);
      else if (!wr_accept && rd_accept) count_nx = count_q - CW'(1);
    end
  end

  // Pointer, count and flag registers; flags come from the next count so
  // they change on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_nx;
      rd_ptr_q <= rd_ptr_nx;
      count_q  <= count_nx;
      full_q   <= (count_nx == DEPTH_C);
      empty_q  <= (count_nx == '0);
      af_q     <= (count_nx >= AF_C);
      ae_q     <= (count_nx <= AE_C);
    end
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en && full_q && !flush) ovf_q <= 1'b1;
      else if (clr_err)              ovf_q <= 1'b0;
      if (rd_en && empty_q && !flush) unf_q <= 1'b1;
      else if (clr_err)               unf_q <= 1'b0;
    end
  end

  // Output staging: dout_valid for standard reads, and a bypass for FWFT
  // when the word being written is the one that becomes the head (the
  // RAM read port would otherwise return the stale entry at that address).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q       <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      dv_q      <= rd_accept;
      byp_sel_q <= wr_accept && (wr_ptr_q == rd_ptr_nx);
      if (wr_accept) byp_data_q <= din;
    end
  end

  // Standard mode reads only on an accepted pop; FWFT keeps prefetching
  // whatever will be the head after this edge.
  assign ram_rd_en   = (MODE == FIFO_FWFT) ? 1'b1      : rd_accept;
  assign ram_rd_addr = (MODE == FIFO_FWFT) ? rd_ptr_nx : rd_ptr_q;

  pico_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign head = byp_sel_q ? byp_data_q : ram_rd_data;

  assign dout         = (MODE == FIFO_FWFT) ? (empty_q ? '0 : head) : ram_rd_data;
  assign dout_valid   = (MODE == FIFO_FWFT) ? !empty_q : dv_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_pico_fifo_param.sv
// Directed bench for pico_fifo_param. Three instances share clock and
// reset: [0] standard 8x16 (AF=14, AE=2), [1] standard 8x4, [2] FWFT 8x16.
module tb_pico_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] wr_en, rd_en, flush, clr_err;
  logic [7:0] din  [3];
  logic [7:0] dout [3];
  logic [2:0] dv, full, empty, af, ae, ovf, unf;
  logic [4:0] cnt  [3];
  logic [2:0] cnt4;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  logic [7:0] t1_data [8] = '{8'hC3, 8'hB9, 8'h0E, 8'hB5, 8'h22, 8'h56, 8'hFE, 8'h61};

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  pico_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .din(din[0]), .rd_en(rd_en[0]),
    .dout(dout[0]), .dout_valid(dv[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]), .flush(flush[0]),
    .overflow(ovf[0]), .underflow(unf[0]), .clr_err(clr_err[0])
  );

  pico_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_std4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .din(din[1]), .rd_en(rd_en[1]),
    .dout(dout[1]), .dout_valid(dv[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt4), .flush(flush[1]),
    .overflow(ovf[1]), .underflow(unf[1]), .clr_err(clr_err[1])
  );
  assign cnt[1] = {2'b00, cnt4};

  pico_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .din(din[2]), .rd_en(rd_en[2]),
    .dout(dout[2]), .dout_valid(dv[2]), .full(full[2]), .empty(empty[2]),
    .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt[2]), .flush(flush[2]),
    .overflow(ovf[2]), .underflow(unf[2]), .clr_err(clr_err[2])
  );

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    wr_en[i] = 1'b1;
    din[i]   = d;
    exp_q.push_back(d);
    cycle();
    wr_en[i] = 1'b0;
  endtask

  task automatic pop_std(input int i, input string tag);
    rd_en[i] = 1'b1;
    cycle();
    rd_en[i] = 1'b0;
    check(tag, dout[i], exp_q.pop_front());
    check({tag, "_valid"}, dv[i], 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = '0;
    rd_en   = '0;
    flush   = '0;
    clr_err = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (2) cycle();

    // reset values on every instance
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_count%0d", i), cnt[i], 0);
      check($sformatf("rst_empty%0d", i), empty[i], 1);
      check($sformatf("rst_full%0d", i), full[i], 0);
      check($sformatf("rst_ae%0d", i), ae[i], 1);
      check($sformatf("rst_af%0d", i), af[i], 0);
      check($sformatf("rst_dout%0d", i), dout[i], 0);
      check($sformatf("rst_dv%0d", i), dv[i], 0);
      check($sformatf("rst_ovf%0d", i), ovf[i], 0);
      check($sformatf("rst_unf%0d", i), unf[i], 0);
    end
    rst_n = 1'b1;
    cycle();

    // 1: eight writes then back-to-back reads, standard mode
    for (int k = 0; k < 8; k++) push(0, t1_data[k]);
    check("t1_count8", cnt[0], 8);
    check("t1_empty0", empty[0], 0);
    rd_en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check($sformatf("t1_dout%0d", k), dout[0], exp_q.pop_front());
      check($sformatf("t1_dv%0d", k), dv[0], 1);
    end
    rd_en[0] = 1'b0;
    check("t1_count0", cnt[0], 0);
    check("t1_empty1", empty[0], 1);
    cycle();
    check("t1_dv_idle", dv[0], 0);
    check("t1_dout_hold", dout[0], 8'h61);

    // 2: depth-4 full, overflow, wrap
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
    check("t2_full", full[1], 1);
    check("t2_count4", cnt[1], 4);
    wr_en[1] = 1'b1; din[1] = 8'h55;
    cycle();
    wr_en[1] = 1'b0;
    check("t2_ovf", ovf[1], 1);
    check("t2_count_still4", cnt[1], 4);
    pop_std(1, "t2_first");
    check("t2_count3", cnt[1], 3);
    push(1, 8'h55);
    check("t2_refull", full[1], 1);
    for (int k = 0; k < 4; k++) pop_std(1, $sformatf("t2_drain%0d", k));
    check("t2_empty", empty[1], 1);

    // 3: FWFT head presentation without rd_en
    push(2, 8'hAB);
    check("t3_dout", dout[2], 8'hAB);
    check("t3_dv", dv[2], 1);
    check("t3_empty0", empty[2], 0);
    cycle();
    check("t3_dout_hold", dout[2], 8'hAB);
    rd_en[2] = 1'b1;
    cycle();
    rd_en[2] = 1'b0;
    void'(exp_q.pop_front());
    check("t3_empty1", empty[2], 1);
    check("t3_dv0", dv[2], 0);
    push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3);
    check("t3_head_c1", dout[2], 8'hC1);
    check("t3_count3", cnt[2], 3);
    rd_en[2] = 1'b1;
    cycle();
    check("t3_head_c2", dout[2], 8'hC2);
    cycle();
    check("t3_head_c3", dout[2], 8'hC3);
    wr_en[2] = 1'b1; din[2] = 8'hC4;
    cycle();
    wr_en[2] = 1'b0; rd_en[2] = 1'b0;
    check("t3_head_c4", dout[2], 8'hC4);
    check("t3_count1", cnt[2], 1);
    check("t3_dv_c4", dv[2], 1);
    rd_en[2] = 1'b1;
    cycle();
    rd_en[2] = 1'b0;
    check("t3_final_empty", empty[2], 1);
    exp_q.delete();

    // 4: simultaneous read/write at count 3, then at count 0
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    for (int k = 0; k < 10; k++) begin
      wr_en[0] = 1'b1; rd_en[0] = 1'b1; din[0] = 8'hD0 + 8'(k);
      exp_q.push_back(din[0]);
      cycle();
      check($sformatf("t4_count%0d", k), cnt[0], 3);
      check($sformatf("t4_dout%0d", k), dout[0], exp_q.pop_front());
    end
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    for (int k = 0; k < 3; k++) pop_std(0, $sformatf("t4_drain%0d", k));
    check("t4_empty", empty[0], 1);
    wr_en[0] = 1'b1; rd_en[0] = 1'b1; din[0] = 8'h5A;
    cycle();
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    exp_q.push_back(8'h5A);
    check("t4_count1", cnt[0], 1);
    check("t4_unf", unf[0], 1);
    check("t4_dv_rej", dv[0], 0);
    pop_std(0, "t4_kept");
    clr_err[0] = 1'b1;
    cycle();
    clr_err[0] = 1'b0;
    check("t4_unf_clr", unf[0], 0);

    // 5: almost flags on the exact edges
    for (int k = 1; k <= 16; k++) begin
      push(0, 8'h40 + 8'(k));
      check($sformatf("t5_count%0d", k), cnt[0], k);
      check($sformatf("t5_ae%0d", k), ae[0], (k <= 2) ? 1 : 0);
      check($sformatf("t5_af%0d", k), af[0], (k >= 14) ? 1 : 0);
    end
    check("t5_full", full[0], 1);
    wr_en[0] = 1'b1; din[0] = 8'hEE;
    cycle();
    wr_en[0] = 1'b0;
    check("t5_ovf", ovf[0], 1);
    check("t5_count16", cnt[0], 16);
    for (int k = 0; k < 9; k++) pop_std(0, $sformatf("t5_pop%0d", k));
    check("t5_count7", cnt[0], 7);

    // 6: flush with concurrent write, error clearing, async reset
    wr_en[0] = 1'b1; flush[0] = 1'b1; din[0] = 8'h77;
    cycle();
    wr_en[0] = 1'b0; flush[0] = 1'b0;
    exp_q.delete();
    check("t6_count0", cnt[0], 0);
    check("t6_empty", empty[0], 1);
    check("t6_ae", ae[0], 1);
    check("t6_dv", dv[0], 0);
    check("t6_ovf_kept", ovf[0], 1);
    check("t6_unf", unf[0], 0);
    rd_en[0] = 1'b1; clr_err[0] = 1'b1;
    cycle();
    rd_en[0] = 1'b0;
    check("t6_set_wins", unf[0], 1);
    check("t6_ovf_clr", ovf[0], 0);
    cycle();
    clr_err[0] = 1'b0;
    check("t6_unf_clr", unf[0], 0);

    push(0, 8'hB1); push(0, 8'hB2); push(0, 8'hB3);
    pop_std(0, "t6_pre_b1");
    wr_en[0] = 1'b1; din[0] = 8'hB4;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_count", cnt[0], 0);
    check("t6_arst_empty", empty[0], 1);
    check("t6_arst_dout", dout[0], 0);
    check("t6_arst_dv", dv[0], 0);
    check("t6_arst_ae", ae[0], 1);
    wr_en[0] = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b1;
    cycle();
    push(0, 8'hE7);
    check("t6_post_count", cnt[0], 1);
    pop_std(0, "t6_post_e7");
    check("t6_post_empty", empty[0], 1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pico_fifo_param.md
Name: pico_fifo_param

Overview:
- Parametrised successor of the single-channel byte FIFO between Pico1 and Pico2 in the dual-PicoBlaze XTEA system.
- Adds the following, none of which the current FIFO has:
  - configurable width and depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - occupancy count and programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between producer PicoBlaze output ports and consumer PicoBlaze input ports; usable for wider XTEA block transfers.

Parameters:
- WIDTH, 8, data word width in bits (1..64).
- DEPTH, 16, number of entries. Must be a power of 2, at least 2.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request (pop).
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout holds valid popped/head data.
- full  out  1  count == DEPTH.
- empty  out  1  no readable data.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  stored entries.
- flush  in  1  synchronous clear of contents.
- overflow  out  1  sticky: wr_en while full.
- underflow  out  1  sticky: rd_en while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers = 0, count = 0, dout = 0, dout_valid = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - overflow = 0, underflow = 0
- Write acceptance:
  - Write is accepted iff wr_en && !full && !flush.
  - Data is stored at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH)-bit pointer).
- Read acceptance:
  - Read is accepted iff rd_en && !empty && !flush.
  - rd_ptr increments modulo DEPTH.
- Standard mode (FWFT=0):
  - dout is registered with 1-cycle latency: an accepted read at edge N gives dout = mem[rd_ptr] and dout_valid = 1 after edge N.
  - dout_valid = 0 after any edge without an accepted read.
  - dout holds its last value.
  - empty = (count == 0).
- FWFT mode (FWFT=1):
  - dout continuously presents the head entry; dout_valid = !empty.
  - A word written into an empty FIFO appears on dout with dout_valid = 1 one cycle after the write edge.
  - rd_en acknowledges and pops the head; the next entry is presented on the following cycle.
- Simultaneous accepted read and write:
  - count is unchanged; full and empty are unchanged.
  - Writing when full is rejected even if rd_en is also high.
  - Reading when empty is rejected even if wr_en is also high. The write is still accepted and count becomes 1.
- Count and flags:
  - count changes by +1 for an accepted write only, -1 for an accepted read only, 0 otherwise.
  - All flags are derived registers: valid on the same edge as count, with no extra lag.
- Flush:
  - On the next edge: pointers = 0, count = 0, dout_valid = 0, empty = 1.
  - Any concurrent wr_en or rd_en is dropped and does not set the error flags.
  - Error flags are unaffected by flush.
- Error flags:
  - overflow is set on wr_en && full && !flush.
  - underflow is set on rd_en && empty && !flush.
  - Both hold until clr_err or reset.
  - If clr_err coincides with a new error event, set wins.
- Reset mid-transfer:
  - All state is lost immediately (asynchronous).
  - Outputs take reset values while rst_n is low.
  - The first accepted write after rst_n rises goes to address 0.
- Memory:
  - No reset on storage array.
  - Read-before-write is irrelevant because the same address cannot be read and written in an accepted op unless count is 0 (read rejected) or DEPTH (write rejected).

Decomposition:
- Package pico_fifo_pkg holds:
  - function clog2_cnt(depth), returning the count width
  - typedef fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - default threshold constants
- One sub-module, pico_fifo_ram: a simple dual-port RAM, WIDTH x DEPTH, with synchronous write and read ports. It is instantiated once. Control, flags and FWFT output staging live in pico_fifo_param.

Test Plan:
1. FWFT=0, WIDTH=8, DEPTH=16: write C3,B9,0E,B5,22,56,FE,61, then 8 reads → dout sequence C3..61, each one cycle after rd_en; count returns to 0; empty = 1.
2. DEPTH=4, fill with 11,22,33,44 → full = 1, count = 4. Then wr_en with 55 → overflow = 1 and the FIFO content is unchanged. Then one read → 11; write 55 wraps to addr 0. Draining gives 22,33,44,55.
3. FWFT=1: single write AB into the empty FIFO → dout = AB with dout_valid = 1 one cycle later, with no rd_en. rd_en → empty = 1 and dout_valid = 0 on the next edge.
4. Simultaneous rd_en/wr_en at count = 3 holds count = 3 over 10 cycles with FIFO order preserved. The same stimulus at count = 0 gives count = 1, underflow = 1, write kept.
5. Thresholds with AF_THRESH=14, AE_THRESH=2:
   - count 2 → almost_empty = 1; count 3 → almost_empty = 0
   - count 13 → almost_full = 0; count 14 → almost_full = 1
   - check on the exact edges
6. Flush asserted with wr_en at count = 7 → next edge count = 0, empty = 1, overflow unchanged. clr_err clears the sticky flags. An async rst_n pulse mid-burst forces all outputs to reset values before the next clk edge.
